// File: rtl/spi_master.sv
// SPI mode-0 master: one WIDTH-bit word per frame, MSB first,
// with chip-select framing and a start/ready handshake.
module spi_master #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iTx_Data,
  output logic             oReady,
  output logic [WIDTH-1:0] oRx_Data,
  output logic             oRx_Valid,
  output logic             oSCLK,
  output logic             oCS_N,
  output logic             oMOSI,
  input  logic             iMISO
);

  localparam int DMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int DW   = $clog2(DMAX);
  localparam int BW   = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_div;
  logic [BW-1:0]    r_bits;
  // bits still to send after the one on oMOSI, left-aligned
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx;

  logic w_div_done;
  logic w_gap_done;
  logic w_accept;
  logic w_enter_high;
  logic w_enter_low;
  logic w_done;
  logic w_frame;
  logic w_mosi;

  assign w_div_done = (r_div == DW'(CLK_DIV - 1));
  assign w_gap_done = (r_div == DW'(CS_GAP - 1));

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (iStart) w_next = S_SETUP;
      S_SETUP: if (w_div_done) w_next = S_HIGH;
      S_HIGH:
        if (w_div_done)
          w_next = (r_bits == BW'(WIDTH)) ? S_HOLD : S_LOW;
      S_LOW:   if (w_div_done) w_next = S_HIGH;
      S_HOLD:  if (w_div_done) w_next = S_GAP;
      S_GAP:   if (w_gap_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // transition events and next registered output values
  always_comb begin
    w_accept     = (r_state == S_IDLE) && iStart;
    w_enter_high = (w_next == S_HIGH) && (r_state != S_HIGH);
    w_enter_low  = (w_next == S_LOW) && (r_state != S_LOW);
    w_done       = (r_state == S_HOLD) && (w_next == S_GAP);
    w_frame      = (w_next == S_SETUP) || (w_next == S_HIGH) ||
                   (w_next == S_LOW) || (w_next == S_HOLD);
    w_mosi       = oMOSI;
    if (!w_frame)
      w_mosi = 1'b0;
    else if (w_accept)
      w_mosi = iTx_Data[WIDTH-1];
    else if (w_enter_low)
      w_mosi = r_tx[WIDTH-1];
  end

  // state register
  always_ff @(posedge iCLK) begin
    if (iRST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // divider restarts on every state change
  always_ff @(posedge iCLK) begin
    if (iRST || (w_next != r_state)) r_div <= '0;
    else                             r_div <= r_div + 1'b1;
  end

  // shift registers and bit counter
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_tx   <= '0;
      r_rx   <= '0;
      r_bits <= '0;
    end else begin
      if (w_accept) begin
        r_tx   <= {iTx_Data[WIDTH-2:0], 1'b0};
        r_bits <= '0;
      end
      if (w_enter_high) begin
        r_rx   <= {r_rx[WIDTH-2:0], iMISO};
        r_bits <= r_bits + 1'b1;
      end
      if (w_enter_low)
        r_tx <= {r_tx[WIDTH-2:0], 1'b0};
    end
  end

  // registered outputs track the state being entered
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oReady    <= 1'b1;
      oCS_N     <= 1'b1;
      oSCLK     <= 1'b0;
      oMOSI     <= 1'b0;
      oRx_Valid <= 1'b0;
      oRx_Data  <= '0;
    end else begin
      oReady    <= (w_next == S_IDLE);
      oCS_N     <= !w_frame;
      oSCLK     <= (w_next == S_HIGH);
      oMOSI     <= w_mosi;
      oRx_Valid <= w_done;
      if (w_done) oRx_Data <= r_rx;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: loopback, constant MISO, slave model,
// busy start, back-to-back and reset scenarios.
module tb_spi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] txd;
  logic        ready;
  logic [31:0] rxd;
  logic        valid;
  logic        sclk;
  logic        csn;
  logic        mosi;
  logic        miso;

  spi_master #(.WIDTH(32), .CLK_DIV(4), .CS_GAP(2)) dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .iTx_Data(txd),
    .oReady(ready), .oRx_Data(rxd), .oRx_Valid(valid),
    .oSCLK(sclk), .oCS_N(csn), .oMOSI(mosi), .iMISO(miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;
  logic [31:0] sbq[$];

  // 0: MISO=0, 1: MISO=1, 2: loopback, 3: slave model
  int   mode = 0;
  logic s_miso = 1'b0;
  logic [31:0] s_word = '0;
  logic [31:0] s_sh = '0;
  logic [31:0] s_rx = '0;

  assign miso = (mode == 0) ? 1'b0 :
                (mode == 1) ? 1'b1 :
                (mode == 2) ? mosi : s_miso;

  int n_valid = 0, valid_cyc = 0, rdy_cyc = 0;
  int n_cslow = 0, n_rise = 0, first_rise_cyc = 0;
  int mosi_bad = 0, hi_run = 0, n_falls = 0;
  int gaps[64];
  bit first_pending = 0;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_ready = 1'b1;
  logic [31:0] exp_w;

  // output monitor, scoreboard and mode-0 slave model
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      valid_cyc = cyc;
      checks++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got strobe data %h, required no strobe", rxd);
      end else begin
        exp_w = sbq.pop_front();
        if (rxd !== exp_w) begin
          fails++;
          $display("FAIL sb_rx_data: got %h required %h", rxd, exp_w);
        end
      end
    end
    if (!p_ready && ready) rdy_cyc = cyc;
    if (!csn) n_cslow++;
    if (p_cs && !csn) begin
      gaps[n_falls % 64] = hi_run;
      n_falls++;
      s_sh = s_word;
      s_miso = s_word[31];
      first_pending = 1;
    end
    if (csn) hi_run++;
    else     hi_run = 0;
    if (!p_sclk && sclk) begin
      n_rise++;
      if (first_pending) begin
        first_rise_cyc = cyc;
        first_pending = 0;
      end
      s_rx = {s_rx[30:0], mosi};
      if (mosi !== p_mosi) mosi_bad++;
    end
    if (p_sclk && !sclk && !csn) begin
      s_sh = s_sh << 1;
      s_miso = s_sh[31];
    end
    p_cs = csn;
    p_sclk = sclk;
    p_mosi = mosi;
    p_ready = ready;
  end

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (!ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout: got oReady=0 required 1");
    end
    @(negedge clk);
  endtask

  task automatic wait_valids(input int base, input int n);
    int k = 0;
    while (n_valid < base + n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (n_valid < base + n) begin
      checks++;
      fails++;
      $display("FAIL valid_timeout: got %0d strobes required %0d", n_valid - base, n);
    end
  endtask

  task automatic start_txn(input logic [31:0] d, output int acc);
    @(negedge clk);
    txd = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
    txd = ~d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({csn, sclk, mosi, ready, valid} !== 5'b10010) begin
      fails++;
      $display("FAIL reset_idle_ctrl: got cs/sclk/mosi/rdy/vld=%b required 10010",
               {csn, sclk, mosi, ready, valid});
    end
    checks++;
    if (rxd !== 32'h0) begin
      fails++;
      $display("FAIL reset_idle_rxd: got %h required 00000000", rxd);
    end
    rst = 1'b0;
  endtask

  task automatic test_loopback();
    int acc, bv, br, bc;
    mode = 2;
    wait_ready();
    bv = n_valid; br = n_rise; bc = n_cslow;
    sbq.push_back(32'hA5C30F81);
    start_txn(32'hA5C30F81, acc);
    wait_valids(bv, 1);
    wait_ready();
    checks++;
    if (n_rise - br !== 32) begin
      fails++;
      $display("FAIL lb_rises: got %0d required 32", n_rise - br);
    end
    checks++;
    if (first_rise_cyc - acc !== 4) begin
      fails++;
      $display("FAIL lb_first_rise: got t=%0d required t=5", first_rise_cyc - acc + 1);
    end
    checks++;
    if (n_cslow - bc !== 260) begin
      fails++;
      $display("FAIL lb_cs_low: got %0d required 260", n_cslow - bc);
    end
    checks++;
    if (valid_cyc - acc !== 260) begin
      fails++;
      $display("FAIL lb_valid_time: got t=%0d required t=261", valid_cyc - acc + 1);
    end
    checks++;
    if (rdy_cyc - acc !== 262) begin
      fails++;
      $display("FAIL lb_ready_time: got t=%0d required t=263", rdy_cyc - acc + 1);
    end
    checks++;
    if (n_valid - bv !== 1) begin
      fails++;
      $display("FAIL lb_strobes: got %0d required 1", n_valid - bv);
    end
  endtask

  task automatic test_const_miso();
    int acc, bv;
    mode = 1;
    bv = n_valid;
    sbq.push_back(32'hFFFFFFFF);
    start_txn(32'h12345678, acc);
    wait_valids(bv, 1);
    wait_ready();
    mode = 0;
    bv = n_valid;
    sbq.push_back(32'h00000000);
    start_txn(32'hFFFFFFFF, acc);
    wait_valids(bv, 1);
    wait_ready();
  endtask

  task automatic test_slave();
    int acc, bv, bb, br;
    mode = 3;
    s_word = 32'h0000002A;
    bv = n_valid; bb = mosi_bad; br = n_rise;
    sbq.push_back(32'h0000002A);
    start_txn(32'h12345678, acc);
    wait_valids(bv, 1);
    wait_ready();
    checks++;
    if (s_rx !== 32'h12345678) begin
      fails++;
      $display("FAIL slave_rx: got %h required 12345678", s_rx);
    end
    checks++;
    if (mosi_bad - bb !== 0) begin
      fails++;
      $display("FAIL slave_mosi_stable: got %0d changes at rise required 0", mosi_bad - bb);
    end
    checks++;
    if (n_rise - br !== 32) begin
      fails++;
      $display("FAIL slave_rises: got %0d required 32", n_rise - br);
    end
  endtask

  task automatic test_busy_start();
    int acc, bv, bc;
    mode = 2;
    bv = n_valid; bc = n_cslow;
    sbq.push_back(32'h0F0F1234);
    start_txn(32'h0F0F1234, acc);
    while (cyc < acc + 49) @(negedge clk);
    txd = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valids(bv, 1);
    wait_ready();
    idle_wait(300);
    checks++;
    if (n_valid - bv !== 1) begin
      fails++;
      $display("FAIL busy_strobes: got %0d required 1", n_valid - bv);
    end
    checks++;
    if (n_cslow - bc !== 260) begin
      fails++;
      $display("FAIL busy_cs_low: got %0d required 260", n_cslow - bc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    int bv, f0, k;
    w[0] = 32'h3C3CA001;
    w[1] = 32'h80000001;
    w[2] = 32'h7FFFFFFE;
    mode = 2;
    bv = n_valid;
    f0 = n_falls;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      @(negedge clk);
      while (!ready && k < 400) begin
        @(negedge clk);
        k++;
      end
      if (!ready) begin
        checks++;
        fails++;
        $display("FAIL b2b_ready_timeout: got oReady=0 required 1");
      end
      txd = w[i];
      start = 1'b1;
      sbq.push_back(w[i]);
      @(posedge clk);
      #1;
      txd = 32'hDEADBEEF;
      if (i == 2) start = 1'b0;
    end
    wait_valids(bv, 3);
    wait_ready();
    idle_wait(300);
    checks++;
    if (n_valid - bv !== 3) begin
      fails++;
      $display("FAIL b2b_strobes: got %0d required 3", n_valid - bv);
    end
    checks++;
    if (gaps[(f0 + 1) % 64] !== 3) begin
      fails++;
      $display("FAIL b2b_gap1: got %0d required 3", gaps[(f0 + 1) % 64]);
    end
    checks++;
    if (gaps[(f0 + 2) % 64] !== 3) begin
      fails++;
      $display("FAIL b2b_gap2: got %0d required 3", gaps[(f0 + 2) % 64]);
    end
    checks++;
    if (sbq.size() !== 0) begin
      fails++;
      $display("FAIL b2b_sb_left: got %0d pending required 0", sbq.size());
    end
  endtask

  task automatic test_reset_mid();
    int acc, bv, br, k;
    mode = 1;
    bv = n_valid; br = n_rise;
    start_txn(32'hA5A5A5A5, acc);
    k = 0;
    while (n_rise - br < 10 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (n_rise - br < 10) begin
      checks++;
      fails++;
      $display("FAIL rstmid_rise_timeout: got %0d rises required 10", n_rise - br);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({csn, sclk, mosi, ready, valid} !== 5'b10010) begin
      fails++;
      $display("FAIL rstmid_ctrl: got cs/sclk/mosi/rdy/vld=%b required 10010",
               {csn, sclk, mosi, ready, valid});
    end
    checks++;
    if (rxd !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_rxd: got %h required 00000000", rxd);
    end
    rst = 1'b0;
    idle_wait(300);
    checks++;
    if (n_valid - bv !== 0) begin
      fails++;
      $display("FAIL rstmid_strobes: got %0d required 0", n_valid - bv);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    txd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_loopback();
    test_const_miso();
    test_slave();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
